// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register-file write port.
// slave = arbiter view, master = requester / register-file side.
interface regfile_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        flush;
  logic        wr_stall;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        busy;

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    input  flush, wr_stall,
    output wr_en, wr_reg, wr_data, busy
  );

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    output flush, wr_stall,
    input  wr_en, wr_reg, wr_data, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a single output stage.
// Define WB_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module regfile_wb_arbiter (
  input logic                  clk,
  input logic                  rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic        stg_vld_q, stg_vld_d;
  logic [4:0]  stg_reg_q, stg_reg_d;
  logic [31:0] stg_data_q, stg_data_d;
  logic        grant0, grant1;
  logic        can_accept;
  logic        xfer0, xfer1;
  logic [4:0]  sel_reg;
  logic [31:0] sel_data;

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`else
  logic last_gnt_q, last_gnt_d;

  // On contention, the requester that was not granted last time wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_gnt_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_gnt_q);
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (xfer0) begin
      last_gnt_d = 1'b0;
    end else if (xfer1) begin
      last_gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // rst_n gates acceptance so readies stay low throughout reset.
  always_comb begin
    can_accept = rst_n & ~bus.flush & (~stg_vld_q | ~bus.wr_stall);
    xfer0      = grant0 & can_accept;
    xfer1      = grant1 & can_accept;
  end

  always_comb begin
    bus.req0_ready = xfer0;
    bus.req1_ready = xfer1;
  end

  always_comb begin
    sel_reg  = bus.req0_reg;
    sel_data = bus.req0_data;
    if (xfer1) begin
      sel_reg  = bus.req1_reg;
      sel_data = bus.req1_data;
    end
  end

  // Flush dominates stall; a transfer refills a draining stage with no bubble;
  // register 0 is accepted but leaves the stage empty.
  always_comb begin
    stg_vld_d  = stg_vld_q;
    stg_reg_d  = stg_reg_q;
    stg_data_d = stg_data_q;
    if (bus.flush) begin
      stg_vld_d = 1'b0;
    end else if (xfer0 | xfer1) begin
      stg_vld_d  = (sel_reg != 5'd0);
      stg_reg_d  = sel_reg;
      stg_data_d = sel_data;
    end else if (stg_vld_q & ~bus.wr_stall) begin
      stg_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld_q  <= 1'b0;
      stg_reg_q  <= '0;
      stg_data_q <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      stg_reg_q  <= stg_reg_d;
      stg_data_q <= stg_data_d;
    end
  end

  always_comb begin
    bus.wr_en   = stg_vld_q & ~bus.wr_stall;
    bus.wr_reg  = stg_reg_q;
    bus.wr_data = stg_data_q;
    bus.busy    = stg_vld_q & bus.wr_stall;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.wr_stall   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle();
    bus.req0_reg  = '0;
    bus.req0_data = '0;
    bus.req1_reg  = '0;
    bus.req1_data = '0;

    // Reset: outputs cleared, readies low even with valids high
    tick();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst_wr_en",   {31'd0, bus.wr_en},      32'd0);
    chk("rst_busy",    {31'd0, bus.busy},       32'd0);
    chk("rst_wr_reg",  {27'd0, bus.wr_reg},     32'd0);
    chk("rst_wr_data", bus.wr_data,             32'd0);
    chk("rst_rdy0",    {31'd0, bus.req0_ready}, 32'd0);
    chk("rst_rdy1",    {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();

    // Contention right after reset
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd5; bus.req0_data = 32'hAAAA0000;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd6; bus.req1_data = 32'hBBBB0000;
    #1;
    chk("c1_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("c1_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    chk("c2_wr_en",   {31'd0, bus.wr_en},  32'd1);
    chk("c2_wr_reg",  {27'd0, bus.wr_reg}, 32'd5);
    chk("c2_wr_data", bus.wr_data,         32'hAAAA0000);
`ifdef WB_ARB_FIXED_PRIO_EN
    chk("c2_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("c2_rdy1", {31'd0, bus.req1_ready}, 32'd0);
`else
    chk("c2_rdy0", {31'd0, bus.req0_ready}, 32'd0);
    chk("c2_rdy1", {31'd0, bus.req1_ready}, 32'd1);
`endif
    tick();
    idle();
    #1;
    chk("c3_wr_en", {31'd0, bus.wr_en}, 32'd1);
`ifdef WB_ARB_FIXED_PRIO_EN
    chk("c3_wr_reg",  {27'd0, bus.wr_reg}, 32'd5);
    chk("c3_wr_data", bus.wr_data,         32'hAAAA0000);
`else
    chk("c3_wr_reg",  {27'd0, bus.wr_reg}, 32'd6);
    chk("c3_wr_data", bus.wr_data,         32'hBBBB0000);
`endif
    tick();
    chk("c4_wr_en", {31'd0, bus.wr_en}, 32'd0);

    // Back-to-back req0 writes r1..r4, no bubble
    for (int unsigned i = 1; i <= 4; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_reg   = 5'(i);
      bus.req0_data  = 32'h100 + i;
      #1;
      chk("b2b_rdy0", {31'd0, bus.req0_ready}, 32'd1);
      if (i > 1) begin
        chk("b2b_wr_en",  {31'd0, bus.wr_en},  32'd1);
        chk("b2b_wr_reg", {27'd0, bus.wr_reg}, 32'(i - 1));
        chk("b2b_wr_data", bus.wr_data,        32'h100 + i - 1);
      end
      tick();
    end
    idle();
    #1;
    chk("b2b_last_wr_en",  {31'd0, bus.wr_en},  32'd1);
    chk("b2b_last_wr_reg", {27'd0, bus.wr_reg}, 32'd4);
    tick();
    chk("b2b_drain", {31'd0, bus.wr_en}, 32'd0);

    // Stall holds r7 for 3 cycles with both requesters waiting
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd7; bus.req0_data = 32'h12345678;
    tick();
    bus.req0_reg = 5'd8; bus.req0_data = 32'h0;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd9; bus.req1_data = 32'h0;
    bus.wr_stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      #1;
      chk("stall_busy",  {31'd0, bus.busy},       32'd1);
      chk("stall_wr_en", {31'd0, bus.wr_en},      32'd0);
      chk("stall_rdy0",  {31'd0, bus.req0_ready}, 32'd0);
      chk("stall_rdy1",  {31'd0, bus.req1_ready}, 32'd0);
      chk("stall_reg",   {27'd0, bus.wr_reg},     32'd7);
      chk("stall_data",  bus.wr_data,             32'h12345678);
      tick();
    end
    idle();
    #1;
    chk("unstall_wr_en", {31'd0, bus.wr_en},  32'd1);
    chk("unstall_reg",   {27'd0, bus.wr_reg}, 32'd7);
    chk("unstall_data",  bus.wr_data,         32'h12345678);
    chk("unstall_busy",  {31'd0, bus.busy},   32'd0);
    tick();
    chk("unstall_drain", {31'd0, bus.wr_en}, 32'd0);

    // req1 write to r0: accepted, discarded, still moves the pointer
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd0; bus.req1_data = 32'hDEADBEEF;
    #1;
    chk("r0_rdy1", {31'd0, bus.req1_ready}, 32'd1);
    tick();
    idle();
    #1;
    chk("r0_no_wr", {31'd0, bus.wr_en}, 32'd0);
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd10; bus.req0_data = 32'hA;
    bus.req1_valid = 1'b1; bus.req1_reg = 5'd11; bus.req1_data = 32'hB;
    #1;
    chk("r0_next_rdy0", {31'd0, bus.req0_ready}, 32'd1);
    chk("r0_next_rdy1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    idle();
    #1;
    chk("r0_next_wr_reg", {27'd0, bus.wr_reg}, 32'd10);
    tick();

    // Flush with r9 staged and req0 waiting
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd9; bus.req0_data = 32'h9;
    tick();
    bus.req0_reg = 5'd12; bus.req0_data = 32'hC;
    bus.flush = 1'b1;
    #1;
    chk("fl_rdy0",    {31'd0, bus.req0_ready}, 32'd0);
    chk("fl_wr_en",   {31'd0, bus.wr_en},      32'd1);
    chk("fl_wr_reg",  {27'd0, bus.wr_reg},     32'd9);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("fl_after_wr_en", {31'd0, bus.wr_en},      32'd0);
    chk("fl_after_rdy0",  {31'd0, bus.req0_ready}, 32'd1);
    tick();
    idle();
    #1;
    chk("fl_next_wr_en",  {31'd0, bus.wr_en},  32'd1);
    chk("fl_next_wr_reg", {27'd0, bus.wr_reg}, 32'd12);
    tick();

    // Flush and stall together clear the stage
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd13; bus.req0_data = 32'hD;
    tick();
    idle();
    bus.wr_stall = 1'b1;
    bus.flush    = 1'b1;
    #1;
    chk("fls_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    idle();
    #1;
    chk("fls_wr_en", {31'd0, bus.wr_en}, 32'd0);
    chk("fls_busy2", {31'd0, bus.busy},  32'd0);

    // Reset asserted mid-stall with r3 staged
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd3; bus.req0_data = 32'h3;
    tick();
    idle();
    bus.wr_stall = 1'b1;
    #1;
    chk("rs_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_wr_en",   {31'd0, bus.wr_en}, 32'd0);
    chk("rs_busy0",   {31'd0, bus.busy},  32'd0);
    chk("rs_wr_data", bus.wr_data,        32'd0);
    tick();
    bus.wr_stall = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rs_rel_wr_en", {31'd0, bus.wr_en}, 32'd0);
    tick();
    chk("rs_rel_wr_en2", {31'd0, bus.wr_en}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Ports SHALL be, clock and reset first:
  clk  in  1  single clock; all state updates on posedge
  rst_n  in  1  asynchronous, active-low reset
  req0_valid  in  1  requester 0 (ALU writeback) has a write pending
  req0_reg  in  5  requester 0 destination register
  req0_data  in  32  requester 0 write data
  req0_ready  out  1  requester 0 write accepted this cycle
  req1_valid  in  1  requester 1 (load writeback) has a write pending
  req1_reg  in  5  requester 1 destination register
  req1_data  in  32  requester 1 write data
  req1_ready  out  1  requester 1 write accepted this cycle
  flush  in  1  synchronous abort of the staged write
  wr_stall  in  1  register file write port unavailable this cycle
  wr_en  out  1  register file write enable
  wr_reg  out  5  register file write address
  wr_data  out  32  register file write data
  busy  out  1  staged write is held

Function
REQ-002 The block SHALL hold one output stage (stg_vld, stg_reg, stg_data) and one round-robin pointer (last_gnt, 1 bit).
REQ-003 Handshake: a transfer on reqN SHALL occur on a posedge where reqN_valid and reqN_ready are both high.
REQ-004 Grant: if exactly one valid is high, that requester SHALL be granted; if both are high, the requester not equal to last_gnt SHALL be granted.
REQ-005 reqN_ready = grantN and not flush and (not stg_vld or not wr_stall); it SHALL be combinational and SHALL NOT depend on reqN_data.
REQ-006 last_gnt SHALL update to the accepted requester on every transfer, and SHALL hold otherwise.
REQ-007 Latency: a transfer at edge N SHALL set stg_vld, stg_reg and stg_data at edge N, so wr_en is high in cycle N+1 if wr_stall is low.
REQ-008 Writes to register 0 SHALL be accepted (ready high) and discarded: stg_vld is cleared (or stays clear), and last_gnt still updates.
REQ-009 wr_en = stg_vld and not wr_stall; wr_reg/wr_data = stg_reg/stg_data; busy = stg_vld and wr_stall.
REQ-010 While wr_stall is high and stg_vld is high, the stage SHALL hold its contents unchanged and both readies SHALL be low.
REQ-011 When the stage drains with no new transfer (stg_vld, not wr_stall, no transfer), stg_vld SHALL clear at the next edge.
REQ-012 Drain and fill in the same cycle SHALL be allowed: back-to-back transfers give one wr_en per cycle with no bubble.
REQ-013 Flush SHALL clear stg_vld at the next edge, block any transfer that cycle, and leave last_gnt unchanged.
REQ-014 wr_en SHALL still follow REQ-009 during a flush cycle; flush takes effect from the next cycle.
REQ-015 Flush and wr_stall together SHALL resolve as flush: the stage is cleared.
REQ-016 A requester that drops valid without a transfer SHALL NOT change last_gnt.

Reset
REQ-017 On rst_n low, asynchronously: stg_vld=0, stg_reg=0, stg_data=0, last_gnt=1. As a result, wr_en=0, busy=0, wr_reg=0, wr_data=0, and requester 0 wins the first contention.
REQ-018 Reset asserted mid-stall SHALL discard the staged write, with no wr_en pulse after reset release.
REQ-019 Readies SHALL be low while rst_n is low.

Configuration
REQ-020 Macro WB_ARB_FIXED_PRIO_EN: when defined, REQ-004 SHALL be replaced by fixed priority (requester 0 always wins contention) and last_gnt SHALL be removed.
REQ-021 When the macro is undefined, round-robin per REQ-004/REQ-006 SHALL apply. All other behaviour SHALL be identical in both builds.

Verification
REQ-022 After reset, both valid, req0=(r5,0xAAAA0000) and req1=(r6,0xBBBB0000) held 2 cycles -> wr_en in cycles 2 and 3: first r5/0xAAAA0000, then r6/0xBBBB0000.
REQ-023 req0 only, valid 4 consecutive cycles with reg r1..r4 -> 4 consecutive wr_en cycles in order with no bubble, and req0_ready high every cycle.
REQ-024 Stage holds r7/0x12345678 while wr_stall is high 3 cycles -> busy=1 and wr_en=0 for those cycles, both readies low, then a single wr_en of r7/0x12345678 after stall drops.
REQ-025 req1 write to r0 with data 0xDEADBEEF -> req1_ready=1 and no wr_en in the following cycle; the next contention grants req0.
REQ-026 Stage holds r9 and flush pulses with req0_valid high -> req0_ready=0 in the flush cycle and no wr_en for r9 after that cycle; req0 is accepted the next cycle.
REQ-027 rst_n asserted mid-stall with r3 staged -> wr_en=0 immediately, and no write to r3 after release. With WB_ARB_FIXED_PRIO_EN defined, re-running REQ-022 gives r5 both cycles while req0 stays valid.
